// File: rtl/mem_port_arbiter_if.sv
// Hart-side request/response and memory-side read port of mem_port_arbiter.
// The master modport is the environment: requesters plus the memory that answers them.
interface mem_port_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [NUM_CH-1:0]        req_valid;
    logic [NUM_CH-1:0]        req_ready;
    logic [NUM_CH*ADDR_W-1:0] req_addr;
    logic [NUM_CH*2-1:0]      req_size;
    logic [NUM_CH-1:0]        rsp_valid;
    logic [DATA_W-1:0]        rsp_data;
    logic                     mem_req;
    logic [ADDR_W-1:0]        mem_addr;
    logic [1:0]               mem_size;
    logic [DATA_W-1:0]        mem_rdata;
    logic                     busy;

    modport master (
        output req_valid, req_addr, req_size, mem_rdata,
        input  req_ready, rsp_valid, rsp_data, mem_req, mem_addr, mem_size, busy
    );

    modport slave (
        input  req_valid, req_addr, req_size, mem_rdata,
        output req_ready, rsp_valid, rsp_data, mem_req, mem_addr, mem_size, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// N-channel arbiter onto one single-outstanding memory read port, one buffered request per channel.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index-first priority instead of round-robin.
module mem_port_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int                CH_W   = $clog2(NUM_CH);
    localparam logic [NUM_CH-1:0] CH_ONE = NUM_CH'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state_reg;
    logic [CH_W-1:0]     grant_reg;
    logic [3:0]          wait_cnt_reg;
    logic                mem_req_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [1:0]          mem_size_reg;
    logic [NUM_CH-1:0]   rsp_valid_reg;
    logic [DATA_W-1:0]   rsp_data_reg;
    logic                busy_reg;

    logic [NUM_CH-1:0]   pend;
    logic [ADDR_W-1:0]   addr_buf [NUM_CH];
    logic [1:0]          size_buf [NUM_CH];

    logic [NUM_CH-1:0]   scan_mask;
    logic [CH_W-1:0]     scan_base;
    logic [CH_W:0]       scan_sum;
    logic                pick_any;
    logic [CH_W-1:0]     pick_idx;

`ifdef ARB_FIXED_PRIO_EN
`else
    logic [CH_W-1:0]     ptr_reg;
    logic [CH_W-1:0]     next_ptr;

    assign next_ptr = (grant_reg == CH_W'(NUM_CH - 1)) ? '0 : grant_reg + 1'b1;
`endif

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic              pend_reg;
        logic [ADDR_W-1:0] addr_reg;
        logic [1:0]        size_reg;

        // A buffered request cannot be overwritten: ready is low until RESP for it ends.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pend_reg <= 1'b0;
                addr_reg <= '0;
                size_reg <= '0;
            end else if (state_reg == RESP && grant_reg == CH_W'(gi)) begin
                pend_reg <= 1'b0;
            end else if (bus.req_valid[gi] && !pend_reg) begin
                pend_reg <= 1'b1;
                addr_reg <= bus.req_addr[gi*ADDR_W +: ADDR_W];
                size_reg <= bus.req_size[gi*2 +: 2];
            end
        end

        assign pend[gi]     = pend_reg;
        assign addr_buf[gi] = addr_reg;
        assign size_buf[gi] = size_reg;
    end

    // In RESP the channel just served is masked out and the scan starts one past it.
    always_comb begin
        scan_mask = pend;
        if (state_reg == RESP) scan_mask[grant_reg] = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
        scan_base = '0;
`else
        scan_base = (state_reg == RESP) ? next_ptr : ptr_reg;
`endif
        scan_sum = '0;
        pick_any = 1'b0;
        pick_idx = '0;
        // Descending offsets so the last hit is the nearest channel to scan_base.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            scan_sum = {1'b0, scan_base} + (CH_W+1)'(k);
            if (scan_sum >= (CH_W+1)'(NUM_CH)) scan_sum = scan_sum - (CH_W+1)'(NUM_CH);
            if (scan_mask[scan_sum[CH_W-1:0]]) begin
                pick_any = 1'b1;
                pick_idx = scan_sum[CH_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            wait_cnt_reg  <= '0;
            mem_req_reg   <= 1'b0;
            mem_addr_reg  <= '0;
            mem_size_reg  <= '0;
            rsp_valid_reg <= '0;
            rsp_data_reg  <= '0;
            busy_reg      <= 1'b0;
`ifdef ARB_FIXED_PRIO_EN
`else
            ptr_reg       <= '0;
`endif
        end else begin
            mem_req_reg   <= 1'b0;
            rsp_valid_reg <= '0;
            case (state_reg)
                IDLE, RESP: begin
`ifdef ARB_FIXED_PRIO_EN
`else
                    if (state_reg == RESP) ptr_reg <= next_ptr;
`endif
                    if (pick_any) begin
                        grant_reg    <= pick_idx;
                        mem_req_reg  <= 1'b1;
                        mem_addr_reg <= addr_buf[pick_idx];
                        mem_size_reg <= size_buf[pick_idx];
                        busy_reg     <= 1'b1;
                        state_reg    <= ISSUE;
                    end else begin
                        busy_reg     <= 1'b0;
                        state_reg    <= IDLE;
                    end
                end
                ISSUE: begin
                    wait_cnt_reg <= 4'(MEM_LAT);
                    state_reg    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt_reg == 4'd1) begin
                        rsp_data_reg  <= bus.mem_rdata;
                        rsp_valid_reg <= CH_ONE << grant_reg;
                        state_reg     <= RESP;
                    end else begin
                        wait_cnt_reg  <= wait_cnt_reg - 4'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = ~pend;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_data  = rsp_data_reg;
    assign bus.mem_req   = mem_req_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_size  = mem_size_reg;
    assign bus.busy      = busy_reg;
endmodule
